// File: rtl/uart_cmd_responder_pkg.sv
// Shared definitions for the config-UART command responder: packet layout,
// FSM state encoding, register reset defaults and the parity helper.
package uart_cmd_pkg;

    localparam int PKT_W      = 18;
    localparam int PARITY_BIT = 17;
    localparam int ADDR_MSB   = 16;
    localparam int ADDR_LSB   = 9;
    localparam int DATA_MSB   = 8;
    localparam int DATA_LSB   = 1;
    localparam int WRB_BIT    = 0;

    // Packet as it travels on the wire, MSB first.
    typedef struct packed {
        logic       parity;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wrb;
    } uart_pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNLOAD,
        ST_CAPTURE,
        ST_EXEC,
        ST_TX_WAIT,
        ST_TX_LOAD
    } state_t;

    // Power-on contents of the config register file.
    localparam int NUM_DEFAULTS = 16;
    localparam logic [7:0] CONFIG_DEFAULTS [NUM_DEFAULTS] = '{
        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
        8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF
    };

    // Parity bit that makes a 17-bit body plus the bit odd overall.
    function automatic logic odd_parity(input logic [16:0] body);
        return ~^body;
    endfunction

    // Registers beyond the default table (larger NUMREGS builds) reset to 0.
    function automatic logic [7:0] config_default(input int k);
        if (k < NUM_DEFAULTS)
            return CONFIG_DEFAULTS[k];
        return 8'h00;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_regfile.sv
// NUMREGS x 8 config register file: one synchronous write port, one
// combinational read port sharing the address, flattened view for the
// analog config bus.
module cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int NUMREGS = 16,
    parameter int AW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [7:0]           i_wdata,
    output logic [7:0]           o_rdata,
    output logic [NUMREGS*8-1:0] o_config_bits
);

    logic [NUMREGS-1:0][7:0] r_regs;

    // Storage: reset to the package defaults, otherwise a single write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUMREGS; k++)
                r_regs[k] <= config_default(k);
        end else if (i_we) begin
            r_regs[i_addr] <= i_wdata;
        end
    end

    // The caller only looks at o_rdata for in-range addresses.
    assign o_rdata       = r_regs[i_addr];
    assign o_config_bits = r_regs;

endmodule

// File: rtl/uart_cmd_responder.sv
// Chip-side command processor for the 18-bit config UART. Unloads one packet
// from uart_rx, checks odd parity and address range, writes or reads the
// config register file and hands a reply packet to uart_tx.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int NUMREGS = 16,
    parameter int ERRW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PKT_W-1:0]     rx_data,
    input  logic                 rx_empty,
    output logic                 uld_rx_data,
    output logic [PKT_W-1:0]     tx_data,
    output logic                 ld_tx_data,
    input  logic                 tx_busy,
    output logic [NUMREGS*8-1:0] config_bits,
    output logic [ERRW-1:0]      cmd_err_count,
    output logic                 busy
);

    // Register-file address width; packets carry 8 address bits, so
    // NUMREGS is limited to 256.
    localparam int AW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [PKT_W-1:0] r_cmd;
    logic [PKT_W-1:0] r_tx_data;
    logic [ERRW-1:0]  r_err_cnt;

    logic [7:0]       w_addr;
    logic [7:0]       w_data;
    logic             w_wrb;
    logic             w_par_ok;
    logic             w_addr_ok;
    logic             w_cmd_ok;
    logic [AW-1:0]    w_rf_addr;
    logic [7:0]       w_rdata;
    uart_pkt_t        w_reply;
    logic             w_we;
    logic             w_load_reply;
    logic             w_err_inc;

    // Decode the captured command.
    assign w_addr    = r_cmd[ADDR_MSB:ADDR_LSB];
    assign w_data    = r_cmd[DATA_MSB:DATA_LSB];
    assign w_wrb     = r_cmd[WRB_BIT];
    assign w_par_ok  = (r_cmd[PARITY_BIT] == odd_parity(r_cmd[ADDR_MSB:WRB_BIT]));
    assign w_addr_ok = (int'(w_addr) < NUMREGS);
    assign w_cmd_ok  = w_par_ok & w_addr_ok;
    assign w_rf_addr = w_addr[AW-1:0];

    cmd_regfile #(
        .NUMREGS (NUMREGS),
        .AW      (AW)
    ) u_regfile (
        .clk           (clk),
        .reset         (reset),
        .i_we          (w_we),
        .i_addr        (w_rf_addr),
        .i_wdata       (w_data),
        .o_rdata       (w_rdata),
        .o_config_bits (config_bits)
    );

    // Reply packet: a write echoes the new value, a read returns the current one.
    always_comb begin
        w_reply        = '0;
        w_reply.addr   = w_addr;
        w_reply.data   = w_wrb ? w_rdata : w_data;
        w_reply.wrb    = w_wrb;
        w_reply.parity = odd_parity({w_reply.addr, w_reply.data, w_reply.wrb});
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (!rx_empty) w_next = ST_UNLOAD;
            ST_UNLOAD:  w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_EXEC;
            ST_EXEC:    w_next = w_cmd_ok ? ST_TX_WAIT : ST_IDLE;
            ST_TX_WAIT: if (!tx_busy) w_next = ST_TX_LOAD;
            ST_TX_LOAD: if (tx_busy) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: strobes and per-state datapath enables.
    always_comb begin
        uld_rx_data  = 1'b0;
        ld_tx_data   = 1'b0;
        busy         = (r_state != ST_IDLE);
        w_we         = 1'b0;
        w_load_reply = 1'b0;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_UNLOAD: uld_rx_data = 1'b1;
            ST_EXEC: begin
                w_we         = w_cmd_ok & ~w_wrb;
                w_load_reply = w_cmd_ok;
                w_err_inc    = ~w_cmd_ok;
            end
            ST_TX_LOAD: ld_tx_data = 1'b1;
            default: ;
        endcase
    end

    // Command capture, reply holding register and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd     <= '0;
            r_tx_data <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_state == ST_CAPTURE)
                r_cmd <= rx_data;
            if (w_load_reply)
                r_tx_data <= w_reply;
            if (w_err_inc && (r_err_cnt != {ERRW{1'b1}}))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign tx_data       = r_tx_data;
    assign cmd_err_count = r_err_cnt;

endmodule
